// File: rtl/note_event_queue_if.sv
// Note-event queue port bundle: MIDI/audio-domain inputs and frame-aligned outputs.
// master drives the request side, slave is the queue block itself.
interface note_event_queue_if #(
  parameter int VOICES  = 8,
  parameter int V_WIDTH = 3,
  parameter int DEPTH   = 4
);
  localparam int CNT_W = $clog2(DEPTH) + 1;

  logic               xxxx_zero;
  logic               note_on;
  logic [V_WIDTH-1:0] cur_key_adr;
  logic [7:0]         cur_key_val;
  logic [7:0]         cur_vel_on;
  logic [VOICES-1:0]  keys_on;

  logic               reg_note_on;
  logic [V_WIDTH-1:0] reg_cur_key_adr;
  logic [7:0]         reg_cur_key_val;
  logic [7:0]         reg_cur_vel_on;
  logic [VOICES-1:0]  reg_keys_on;
  logic [CNT_W-1:0]   q_level;
  logic               overflow;

  modport master (
    output xxxx_zero, note_on, cur_key_adr, cur_key_val, cur_vel_on, keys_on,
    input  reg_note_on, reg_cur_key_adr, reg_cur_key_val, reg_cur_vel_on,
           reg_keys_on, q_level, overflow
  );

  modport slave (
    input  xxxx_zero, note_on, cur_key_adr, cur_key_val, cur_vel_on, keys_on,
    output reg_note_on, reg_cur_key_adr, reg_cur_key_val, reg_cur_vel_on,
           reg_keys_on, q_level, overflow
  );
endinterface

// File: rtl/note_event_queue.sv
// Purpose: synchronise MIDI note-on requests and release one queued event per audio frame.
// Latency: input pin to queue write SYNC_STAGES+1 cycles; frame boundary to outputs 1 cycle.
// Backpressure: none; events arriving at a full queue are dropped and flagged in overflow.
module note_event_queue #(
  parameter int VOICES      = 8,
  parameter int V_WIDTH     = 3,
  parameter int DEPTH       = 4,
  parameter int SYNC_STAGES = 2
) (
  input logic AUDIO_CLK,
  input logic reset,
  note_event_queue_if.slave bus
);
  localparam int PTR_W = $clog2(DEPTH);
  localparam int CNT_W = PTR_W + 1;

  typedef struct packed {
    logic [V_WIDTH-1:0] adr;
    logic [7:0]         key;
    logic [7:0]         vel;
  } note_evt_t;

  typedef struct packed {
    logic              zero;
    logic              note;
    note_evt_t         evt;
    logic [VOICES-1:0] keys;
  } in_bundle_t;

  typedef enum logic [1:0] {Q_EMPTY, Q_PARTIAL, Q_FULL} q_state_t;

  in_bundle_t           in_raw;
  in_bundle_t           in_s;
  in_bundle_t           sync_q [SYNC_STAGES];
  logic                 zero_prev;
  logic                 note_prev;
  logic                 note_armed;
  logic [SYNC_STAGES:0] fill_q;
  logic                 fb;
  logic                 ne;

  note_evt_t            mem [DEPTH];
  logic [PTR_W-1:0]     wr_ptr;
  logic [PTR_W-1:0]     rd_ptr;
  logic [CNT_W-1:0]     count;
  logic [CNT_W-1:0]     count_d;
  q_state_t             state_q;
  q_state_t             state_d;
  logic                 push;
  logic                 pop;
  logic                 drop;

  logic                 note_r;
  note_evt_t            cur_r;
  logic [VOICES-1:0]    keys_r;
  logic                 ovf_r;

  assign in_raw = {bus.xxxx_zero, bus.note_on, bus.cur_key_adr,
                   bus.cur_key_val, bus.cur_vel_on, bus.keys_on};
  assign in_s   = sync_q[SYNC_STAGES-1];

  // fill_q marks when the sync chain holds real samples instead of reset zeros;
  // a note_on level is only armed once it has been seen low after that point.
  always_ff @(posedge AUDIO_CLK) begin
    if (reset) begin
      for (int i = 0; i < SYNC_STAGES; i++) sync_q[i] <= '0;
      zero_prev  <= 1'b0;
      note_prev  <= 1'b0;
      note_armed <= 1'b0;
      fill_q     <= '0;
    end else begin
      sync_q[0] <= in_raw;
      for (int i = 1; i < SYNC_STAGES; i++) sync_q[i] <= sync_q[i-1];
      zero_prev <= in_s.zero;
      note_prev <= in_s.note;
      fill_q    <= {fill_q[SYNC_STAGES-1:0], 1'b1};
      if (fill_q[SYNC_STAGES] && !in_s.note) note_armed <= 1'b1;
    end
  end

  assign fb = zero_prev & ~in_s.zero;
  assign ne = note_armed & in_s.note & ~note_prev;

  // Pop is resolved first so a push into a full queue succeeds on a frame boundary.
  always_comb begin
    pop     = fb && (state_q != Q_EMPTY);
    push    = ne && ((state_q != Q_FULL) || pop);
    drop    = ne && !push;
    count_d = count;
    state_d = state_q;
    case ({push, pop})
      2'b10:   count_d = count + CNT_W'(1);
      2'b01:   count_d = count - CNT_W'(1);
      default: count_d = count;
    endcase
    if (push != pop) begin
      if (count_d == '0)                 state_d = Q_EMPTY;
      else if (count_d == CNT_W'(DEPTH)) state_d = Q_FULL;
      else                               state_d = Q_PARTIAL;
    end
  end

  always_ff @(posedge AUDIO_CLK) begin
    if (reset) begin
      state_q <= Q_EMPTY;
      count   <= '0;
      wr_ptr  <= '0;
      rd_ptr  <= '0;
      ovf_r   <= 1'b0;
      note_r  <= 1'b0;
      cur_r   <= '0;
      keys_r  <= '0;
    end else begin
      state_q <= state_d;
      count   <= count_d;
      if (push) wr_ptr <= wr_ptr + PTR_W'(1);
      if (pop)  rd_ptr <= rd_ptr + PTR_W'(1);
      if (drop) ovf_r  <= 1'b1;
      if (fb) begin
        keys_r <= in_s.keys;
        note_r <= pop;
        if (pop) cur_r <= mem[rd_ptr];
      end
    end
  end

  always_ff @(posedge AUDIO_CLK) begin
    if (push) mem[wr_ptr] <= in_s.evt;
  end

  assign bus.reg_note_on     = note_r;
  assign bus.reg_cur_key_adr = cur_r.adr;
  assign bus.reg_cur_key_val = cur_r.key;
  assign bus.reg_cur_vel_on  = cur_r.vel;
  assign bus.reg_keys_on     = keys_r;
  assign bus.q_level         = count;
  assign bus.overflow        = ovf_r;
endmodule

// File: tb/tb_note_event_queue.sv
// Randomised and directed bench for note_event_queue against an event-level queue model.
module tb_note_event_queue;
  localparam int SS    = 2;
  localparam int DEPTH = 4;
  localparam int GAP   = SS + 3;

  typedef struct {
    logic [2:0] adr;
    logic [7:0] key;
    logic [7:0] vel;
  } ev_t;

  logic AUDIO_CLK;
  logic reset;

  note_event_queue_if #(.VOICES(8), .V_WIDTH(3), .DEPTH(DEPTH)) bus ();

  note_event_queue #(.VOICES(8), .V_WIDTH(3), .DEPTH(DEPTH), .SYNC_STAGES(SS)) dut (
    .AUDIO_CLK (AUDIO_CLK),
    .reset     (reset),
    .bus       (bus)
  );

  initial AUDIO_CLK = 1'b0;
  always #5 AUDIO_CLK = ~AUDIO_CLK;

  int   checks = 0;
  int   errors = 0;
  ev_t  m_q[$];
  ev_t  m_cur;
  bit   m_note;
  bit   m_ovf;
  logic [7:0] m_keys;
  logic [7:0] keys_in;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    if (obs !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic tick(input int n);
    repeat (n) @(negedge AUDIO_CLK);
  endtask

  task automatic model_push(input ev_t e);
    if (m_q.size() < DEPTH) m_q.push_back(e);
    else m_ovf = 1'b1;
  endtask

  task automatic model_frame();
    m_keys = keys_in;
    if (m_q.size() > 0) begin
      m_cur  = m_q.pop_front();
      m_note = 1'b1;
    end else begin
      m_note = 1'b0;
    end
  endtask

  task automatic check_state(input string tag);
    chk({tag, "/q_level"},  32'(bus.q_level),     32'(m_q.size()));
    chk({tag, "/overflow"}, 32'(bus.overflow),    32'(m_ovf));
    chk({tag, "/note_on"},  32'(bus.reg_note_on), 32'(m_note));
    chk({tag, "/adr"},      32'(bus.reg_cur_key_adr), 32'(m_cur.adr));
    chk({tag, "/key"},      32'(bus.reg_cur_key_val), 32'(m_cur.key));
    chk({tag, "/vel"},      32'(bus.reg_cur_vel_on),  32'(m_cur.vel));
    chk({tag, "/keys_on"},  32'(bus.reg_keys_on), 32'(m_keys));
  endtask

  // Raise note_on with the given data, optionally with a coincident frame boundary.
  task automatic send_ev(input logic [2:0] a, input logic [7:0] k, input logic [7:0] v,
                         input bit with_fb);
    ev_t e;
    e.adr = a; e.key = k; e.vel = v;
    bus.cur_key_adr = a;
    bus.cur_key_val = k;
    bus.cur_vel_on  = v;
    bus.note_on     = 1'b1;
    if (with_fb) begin
      chk("sim_hold/note_on", 32'(bus.reg_note_on), 32'(m_note));
      bus.xxxx_zero = 1'b0;
    end
    tick(GAP);
    if (with_fb) model_frame();
    model_push(e);
    bus.note_on = 1'b0;
    if (with_fb) bus.xxxx_zero = 1'b1;
    tick(GAP);
    check_state(with_fb ? "sim_ev" : "ev");
  endtask

  task automatic frame();
    chk("hold/note_on", 32'(bus.reg_note_on), 32'(m_note));
    bus.xxxx_zero = 1'b0;
    tick(GAP);
    model_frame();
    check_state("frame");
    bus.xxxx_zero = 1'b1;
    tick(GAP);
  endtask

  task automatic do_reset();
    reset = 1'b1;
    tick(2);
    reset = 1'b0;
    m_q.delete();
    m_cur  = '{adr: 3'd0, key: 8'd0, vel: 8'd0};
    m_note = 1'b0;
    m_ovf  = 1'b0;
    m_keys = 8'd0;
    tick(GAP + 1);
    check_state("reset");
  endtask

  initial begin
    ev_t held;
    reset           = 1'b1;
    bus.xxxx_zero   = 1'b1;
    bus.note_on     = 1'b0;
    bus.cur_key_adr = 3'd0;
    bus.cur_key_val = 8'd0;
    bus.cur_vel_on  = 8'd0;
    keys_in         = 8'd0;
    bus.keys_on     = keys_in;
    tick(2);
    do_reset();

    // Single event.
    send_ev(3'd5, 8'd60, 8'd100, 1'b0);
    frame();
    chk("single/key", 32'(bus.reg_cur_key_val), 32'h3C);
    chk("single/vel", 32'(bus.reg_cur_vel_on),  32'h64);
    frame();

    // keys_on snapshot only moves at a frame boundary.
    keys_in = 8'hA5; bus.keys_on = keys_in;
    tick(GAP);
    frame();
    keys_in = 8'h5A; bus.keys_on = keys_in;
    tick(GAP);
    chk("keys_mid/keys_on", 32'(bus.reg_keys_on), 32'hA5);
    frame();
    chk("keys_after/keys_on", 32'(bus.reg_keys_on), 32'h5A);

    // Burst of three.
    send_ev(3'd0, 8'd60, 8'd10, 1'b0);
    send_ev(3'd1, 8'd64, 8'd20, 1'b0);
    send_ev(3'd2, 8'd67, 8'd30, 1'b0);
    chk("burst/q_level", 32'(bus.q_level), 32'd3);
    repeat (4) frame();

    // Overflow: fifth event lost.
    for (int i = 1; i <= 5; i++) send_ev(3'(i), 8'(i), 8'(i * 3), 1'b0);
    chk("ovf/q_level", 32'(bus.q_level), 32'd4);
    chk("ovf/flag", 32'(bus.overflow), 32'd1);
    repeat (5) frame();

    // Reset with two queued events and note_on held high.
    send_ev(3'd3, 8'd40, 8'd41, 1'b0);
    held.adr = 3'd6; held.key = 8'd99; held.vel = 8'd77;
    bus.cur_key_adr = held.adr; bus.cur_key_val = held.key; bus.cur_vel_on = held.vel;
    bus.note_on = 1'b1;
    tick(GAP);
    model_push(held);
    chk("pre_rst/q_level", 32'(bus.q_level), 32'd2);
    do_reset();
    tick(3 * GAP);
    chk("rst_held/q_level", 32'(bus.q_level), 32'd0);
    frame();
    bus.note_on = 1'b0;
    tick(GAP);
    chk("rst_low/q_level", 32'(bus.q_level), 32'd0);
    bus.note_on = 1'b1;
    tick(GAP);
    model_push(held);
    bus.note_on = 1'b0;
    tick(GAP);
    check_state("rst_retoggle");
    frame();

    // Coincident event and boundary with the queue full, then with it empty.
    for (int i = 0; i < 4; i++) send_ev(3'(i), 8'(20 + i), 8'(50 + i), 1'b0);
    send_ev(3'd7, 8'd88, 8'd90, 1'b1);
    chk("sim_full/q_level", 32'(bus.q_level), 32'd4);
    chk("sim_full/overflow", 32'(bus.overflow), 32'd0);
    repeat (5) frame();
    send_ev(3'd4, 8'd33, 8'd44, 1'b1);
    chk("sim_empty/note_on", 32'(bus.reg_note_on), 32'd0);
    frame();

    // Randomised traffic.
    for (int n = 0; n < 250; n++) begin
      int r;
      r = $urandom_range(0, 9);
      if (r <= 4) begin
        send_ev(3'($urandom_range(0, 7)), 8'($urandom), 8'($urandom), r == 4);
      end else if (r <= 7) begin
        frame();
      end else if (r == 8) begin
        keys_in = 8'($urandom);
        bus.keys_on = keys_in;
        tick(GAP);
        chk("rnd_keys_hold", 32'(bus.reg_keys_on), 32'(m_keys));
      end else if ($urandom_range(0, 3) == 0) begin
        do_reset();
      end else begin
        frame();
      end
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
